// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_fifo
// Brief   : Byte-wide UART transmitter (8N1, LSB first, idle high) fed by a
//           small input FIFO. Define UART_PARITY_EN to add an even-parity bit.
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          sysclk,
  input  logic                          reset,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          UART_TX,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD;
  localparam int CW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int NW       = AW + 1;
  localparam logic [CW-1:0] C_CNT_LAST = CW'(BAUD_DIV - 1);
  localparam logic [NW-1:0] C_FULL     = NW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [NW-1:0] r_count;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_tx;
`ifdef UART_PARITY_EN
  logic          r_par;
`endif

  logic       w_ready;
  logic       w_nonempty;
  logic       w_cnt_end;
  logic       w_push;
  logic       w_pop;
  logic [7:0] w_head;
  logic       w_line;

  assign w_ready    = (r_count != C_FULL);
  assign w_nonempty = (r_count != '0);
  assign w_cnt_end  = (r_cnt == C_CNT_LAST);
  assign w_push     = tx_valid && w_ready;
  // Pop on entry from IDLE, or at the last stop-bit cycle for gapless frames.
  assign w_pop      = w_nonempty &&
                      ((r_state == S_IDLE) || ((r_state == S_STOP) && w_cnt_end));
  assign w_head     = r_mem[r_rd_ptr];

  always_comb begin
    w_line = 1'b1;
    case (r_state)
      S_START: w_line = 1'b0;
      S_DATA:  w_line = r_shift[0];
`ifdef UART_PARITY_EN
      S_PARITY: w_line = r_par;
`endif
      default: w_line = 1'b1;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + NW'(1);
        2'b01:   r_count <= r_count - NW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge sysclk) begin
    if (w_push) r_mem[r_wr_ptr] <= tx_data;
  end

  // The line register follows the current state, so it trails state by a cycle.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
`ifdef UART_PARITY_EN
      r_par     <= 1'b0;
`endif
    end else begin
      r_tx <= w_line;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_shift   <= w_head;
            r_bit_idx <= '0;
            r_cnt     <= '0;
`ifdef UART_PARITY_EN
            r_par     <= ^w_head;
`endif
            r_state   <= S_START;
          end
        end
        S_START: begin
          if (w_cnt_end) begin
            r_cnt   <= '0;
            r_state <= S_DATA;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (w_cnt_end) begin
            r_cnt   <= '0;
            r_shift <= r_shift >> 1;
            if (r_bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
`ifdef UART_PARITY_EN
        S_PARITY: begin
          if (w_cnt_end) begin
            r_cnt   <= '0;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
`endif
        S_STOP: begin
          if (w_cnt_end) begin
            r_cnt <= '0;
            if (w_pop) begin
              r_shift   <= w_head;
              r_bit_idx <= '0;
`ifdef UART_PARITY_EN
              r_par     <= ^w_head;
`endif
              r_state   <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign UART_TX    = r_tx;
  assign tx_ready   = w_ready;
  assign tx_busy    = (r_state != S_IDLE) || w_nonempty;
  assign fifo_count = r_count;

endmodule
`default_nettype wire
